// File: rtl/bcd_conv_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
interface bcd_conv_if #(
    parameter int W      = 21,
    parameter int DIGITS = 7
);
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  sign_out;
    logic [DIGITS-1:0]     digit_blank;
    logic                  busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, bcd_out, sign_out, digit_blank, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, bcd_out, sign_out, digit_blank, busy
    );
endinterface

// File: rtl/bcd_conv_sequencer.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// Define BCD_LEADING_ZERO_BLANK_EN to generate the leading-zero blank mask.
module bcd_conv_sequencer #(
    parameter int W      = 21,
    parameter int DIGITS = 7
) (
    input logic      clk,
    input logic      reset,
    bcd_conv_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * DIGITS;

    if (64'd10 ** DIGITS <= (64'd1 << (W - 1))) begin : g_param_chk
        $error("DIGITS too small to hold 2^(W-1)");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   bin, mag;
    logic [BW-1:0]  acc, acc_cor, acc_nx;
    logic [W-1:0]   bin_nx;
    logic [BW+W-1:0] shifted;
    logic [CW-1:0]  cnt;
    logic           sign, last;
    logic [BW-1:0]  bcd_q;
    logic           sign_q;
    logic           in_ready, out_valid, busy;

    assign last = (cnt == CW'(W - 1));
    assign mag  = bus.in_data[W-1] ? (~bus.in_data + 1'b1) : bus.in_data;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nx = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // All digits are corrected in parallel before the joint shift
    always_comb begin
        acc_cor = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5)
                acc_cor[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
        shifted = {acc_cor, bin} << 1;
        acc_nx  = shifted[BW+W-1:W];
        bin_nx  = shifted[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin    <= '0;
            acc    <= '0;
            cnt    <= '0;
            sign   <= 1'b0;
            bcd_q  <= '0;
            sign_q <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            bin  <= mag;
            sign <= bus.in_data[W-1];
            acc  <= '0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            acc <= acc_nx;
            bin <= bin_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                bcd_q  <= acc_nx;
                sign_q <= sign;
            end
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_nx;

    // Blank every digit above the most significant nonzero one; digit 0 always shows
    always_comb begin
        logic nz;
        nz       = 1'b0;
        blank_nx = '0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (acc_nx[4*k +: 4] != 4'd0) nz = 1'b1;
            blank_nx[k] = ~nz;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            blank_q <= '0;
        else if (state == SHIFT && last)
            blank_q <= blank_nx;
    end

    assign bus.digit_blank = blank_q;
`else
    assign bus.digit_blank = '0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.bcd_out   = bcd_q;
    assign bus.sign_out  = sign_q;
endmodule

// File: tb/tb_bcd_conv_sequencer.sv
// Scoreboard bench for bcd_conv_sequencer: expected digits queued at accept,
// checked on each output handshake together with latency and spacing.
module tb_bcd_conv_sequencer;
    localparam int W      = 21;
    localparam int DIGITS = 7;
    localparam int BW     = 4 * DIGITS;

    typedef struct {
        logic [BW-1:0]     bcd;
        logic              sign;
        logic [DIGITS-1:0] blank;
        int                acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_conv_if #(.W(W), .DIGITS(DIGITS)) bus ();

    bcd_conv_sequencer #(.W(W), .DIGITS(DIGITS)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   b2b = 1'b0;
    int   b2b_n = 0;
    int   last_hs = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] v);
        exp_t   r;
        longint x, m, t;
        int     nd;
        x = longint'($signed(v));
        m = (x < 0) ? -x : x;
        r.sign    = (x < 0);
        r.bcd     = '0;
        r.blank   = '0;
        r.acc_cyc = 0;
        nd = 1;
        t  = m;
        while (t >= 10) begin
            t = t / 10;
            nd++;
        end
        for (int k = 0; k < DIGITS; k++) begin
            r.bcd[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
`ifdef BCD_LEADING_ZERO_BLANK_EN
        r.blank = ~DIGITS'((64'd1 << nd) - 64'd1);
`else
        if (nd < 0) r.blank = '1;
`endif
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (!reset) begin
            if (bus.out_valid && !prev_valid) begin
                if (sb.size() == 0) check("spurious_valid", 64'd1, 64'd0);
                else check("latency", 64'(cyc - sb[0].acc_cyc), 64'(W));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("bcd", 64'(bus.bcd_out), 64'(e.bcd));
                    check("sign", 64'(bus.sign_out), 64'(e.sign));
                    check("blank", 64'(bus.digit_blank), 64'(e.blank));
                end
                if (b2b) begin
                    if (b2b_n > 0) check("spacing", 64'(cyc - last_hs), 64'(W + 2));
                    b2b_n++;
                end
                last_hs = cyc;
            end
        end
        prev_valid = bus.out_valid;
    end

    // Call at a falling edge; returns at the falling edge after the accept
    task automatic send(input logic [W-1:0] v, input bit keep);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                if (keep) begin
                    e = model(v);
                    e.acc_cyc = cyc;
                    sb.push_back(e);
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((sb.size() != 0 || bus.out_valid) && i < 300) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid();
        int i;
        i = 0;
        while (!bus.out_valid && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("valid_seen", 64'(bus.out_valid), 64'd1);
    endtask

    initial begin
        exp_t m777;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_bcd", 64'(bus.bcd_out), 64'd0);
        check("rst_sign", 64'(bus.sign_out), 64'd0);
        check("rst_blank", 64'(bus.digit_blank), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        bus.out_ready = 1'b1;
        send(21'd0, 1'b1);
        bus.in_valid = 1'b0;
        check("shift_busy", 64'(bus.busy), 64'd1);
        check("shift_in_ready", 64'(bus.in_ready), 64'd0);
        drain();

        send(21'd255, 1'b1);
        send(21'h1FFFFF, 1'b1);
        bus.in_valid = 1'b0;
        drain();

        send(21'h0FFFFF, 1'b1);
        send(21'h100000, 1'b1);
        bus.in_valid = 1'b0;
        drain();

        m777 = model(21'd777);
        bus.out_ready = 1'b0;
        send(21'd777, 1'b1);
        bus.in_valid = 1'b0;
        wait_valid();
        bus.in_valid = 1'b1;
        bus.in_data  = 21'd4242;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_bcd", 64'(bus.bcd_out), 64'(m777.bcd));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        check("release_valid", 64'(bus.out_valid), 64'd0);
        check("idle_bcd_held", 64'(bus.bcd_out), 64'(m777.bcd));
        check("release_sb", 64'(sb.size()), 64'd0);

        bus.out_ready = 1'b1;
        send(21'd5000, 1'b0);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_bcd", 64'(bus.bcd_out), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        send(21'd12345, 1'b1);
        bus.in_valid = 1'b0;
        drain();

        b2b_n = 0;
        b2b   = 1'b1;
        send(21'd9, 1'b1);
        send(21'd10, 1'b1);
        send(21'd99, 1'b1);
        bus.in_valid = 1'b0;
        drain();
        b2b = 1'b0;
        check("b2b_count", 64'(b2b_n), 64'd3);

        for (int i = 0; i < 6; i++) begin
            send(W'($urandom_range(0, (1 << W) - 1)), 1'b1);
        end
        bus.in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
